// File: rtl/bram_fifo_if.sv
// bram_fifo_if: FIFO handshake bundle; master drives wr/w_data/rd, slave returns data, status and occupancy
interface bram_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  wr;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  rd;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic                  empty;
  logic                  full;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;
  modport master (
    output wr, w_data, rd,
    input  r_data, r_valid, empty, full, count, overflow, underflow
  );
  modport slave (
    input  wr, w_data, rd,
    output r_data, r_valid, empty, full, count, overflow, underflow
  );
endinterface

// File: rtl/bram_fifo.sv
// bram_fifo: single-clock FIFO on a simple-dual-port block RAM, standard or first-word-fall-through read
// Ports: clk; rst_n (async, active-low); bus = slave side of bram_fifo_if
//   (wr/w_data/rd in; r_data/r_valid/empty/full/count/overflow/underflow out)
module bram_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FWFT       = 0
) (
  input logic        clk,
  input logic        rst_n,
  bram_fifo_if.slave bus
);
  localparam logic [ADDR_WIDTH:0] DEPTH   = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [0:0]          IDLE    = 1'b0;
  localparam logic [0:0]          LOADING = 1'b1;
  (* ram_style = "block" *) logic [DATA_WIDTH-1:0] ram_q [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d, ram_words;
  logic [DATA_WIDTH-1:0] dout_q, out_q, out_d;
  logic [0:0]            state_q, state_d;
  logic                  out_valid_q, out_valid_d, overflow_q, underflow_q;
  logic                  full, empty, wr_acc, pop, move, issue;
  // In FWFT mode count also covers the word in the BRAM output register (LOADING)
  // and the word in the output register, so only the remainder is still in the RAM.
  // In standard mode out_valid_q is simply the one-cycle r_valid pulse of a pop.
  always_comb begin
    full        = count_q == DEPTH;
    empty       = FWFT != 0 ? !out_valid_q : count_q == '0;
    wr_acc      = bus.wr && !full;
    pop         = bus.rd && !empty;
    ram_words   = count_q - (ADDR_WIDTH+1)'(out_valid_q) - (ADDR_WIDTH+1)'(state_q);
    move        = state_q == LOADING && (!out_valid_q || pop);
    issue       = FWFT != 0 ? ram_words != '0 && (state_q == IDLE || move) : pop;
    state_d     = FWFT != 0 ? (issue ? LOADING : move ? IDLE : state_q) : IDLE;
    out_valid_d = FWFT != 0 ? move || (out_valid_q && !pop) : pop;
    out_d       = move ? dout_q : out_q;
    wr_ptr_d    = wr_ptr_q + ADDR_WIDTH'(wr_acc);
    rd_ptr_d    = rd_ptr_q + ADDR_WIDTH'(issue);
    count_d     = count_q + (ADDR_WIDTH+1)'(wr_acc) - (ADDR_WIDTH+1)'(pop);
  end
  always_ff @(posedge clk)
    if (wr_acc) ram_q[wr_ptr_q] <= bus.w_data;
  // A read never targets the address being written: that would need DEPTH unread
  // words in the RAM, in which case the FIFO is full and the write is refused.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      dout_q      <= '0;
      out_q       <= '0;
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      if (issue) dout_q <= ram_q[rd_ptr_q];
      out_q       <= out_d;
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= bus.wr && full;
      underflow_q <= bus.rd && empty;
    end
  assign bus.r_data    = FWFT != 0 ? out_q : dout_q;
  assign bus.r_valid   = out_valid_q;
  assign bus.empty     = empty;
  assign bus.full      = full;
  assign bus.count     = count_q;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
endmodule

// File: tb/tb_bram_fifo.sv
// tb_bram_fifo: standard and FWFT FIFOs (DEPTH=4) against a queue model with word visibility times
module tb_bram_fifo;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  bram_fifo_if #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) f0 ();
  bram_fifo_if #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) f1 ();
  bram_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .FWFT(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(f0));
  bram_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .FWFT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(f1));
  int n_cmp = 0;
  int n_bad = 0;
  // Model: per FIFO a queue of (data, write edge). In FWFT mode a word becomes the
  // visible head two edges after its write, but never before its predecessor is popped.
  logic [7:0] md [2][256];
  int         mwt [2][256];
  int         mh [2], mt [2], lp [2];
  int         e;
  logic [7:0] rdat [2];
  logic       rval [2], ovf [2], unf [2];
  function automatic bit vis(input int m, input int ei);
    int t;
    if (mt[m] == mh[m]) return 1'b0;
    t = mwt[m][mh[m] & 255] + 2;
    if (lp[m] > t) t = lp[m];
    return ei >= t;
  endfunction
  function automatic bit memp(input int m, input int ei);
    return m == 1 ? !vis(m, ei) : mt[m] == mh[m];
  endfunction
  task automatic mreset();
    for (int m = 0; m < 2; m++) begin
      mh[m] = 0; mt[m] = 0; lp[m] = 0;
      rdat[m] = 8'h00; rval[m] = 1'b0; ovf[m] = 1'b0; unf[m] = 1'b0;
    end
  endtask
  task automatic mstep();
    for (int m = 0; m < 2; m++) begin
      logic w, r;
      logic [7:0] d;
      int sz;
      bit em;
      w = m == 0 ? f0.wr : f1.wr;
      r = m == 0 ? f0.rd : f1.rd;
      d = m == 0 ? f0.w_data : f1.w_data;
      sz = mt[m] - mh[m];
      em = memp(m, e);
      ovf[m] = w && sz == 4;
      unf[m] = r && em;
      rval[m] = 1'b0;
      if (r && !em) begin
        rdat[m] = md[m][mh[m] & 255]; rval[m] = 1'b1; mh[m]++; lp[m] = e + 1;
      end
      if (w && sz != 4) begin
        md[m][mt[m] & 255] = d; mwt[m][mt[m] & 255] = e + 1; mt[m]++;
      end
    end
    e++;
  endtask
  initial begin
    e = 0;
    mreset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) mreset(); else mstep();
    end
  end
  task automatic chk(input int m, input string n, input logic [31:0] a, input logic [31:0] x);
    n_cmp++;
    if (a !== x) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %0h, expected %0h at %0t", n, m, a, x, $time);
    end
  endtask
  task automatic cmp_inst(input int m, input logic [7:0] r_data, input logic r_valid,
                          input logic empty, input logic full, input logic [2:0] count,
                          input logic overflow, input logic underflow);
    int sz;
    bit v;
    sz = mt[m] - mh[m];
    v = vis(m, e);
    chk(m, "count", 32'(count), sz);
    chk(m, "full", 32'(full), 32'(sz == 4));
    chk(m, "empty", 32'(empty), 32'(memp(m, e)));
    chk(m, "r_valid", 32'(r_valid), 32'(m == 1 ? v : rval[m]));
    chk(m, "overflow", 32'(overflow), 32'(ovf[m]));
    chk(m, "underflow", 32'(underflow), 32'(unf[m]));
    if (m == 0) chk(m, "r_data", 32'(r_data), 32'(rdat[0]));
    else if (v) chk(m, "r_data", 32'(r_data), 32'(md[1][mh[1] & 255]));
  endtask
  initial forever begin
    @(negedge clk);
    cmp_inst(0, f0.r_data, f0.r_valid, f0.empty, f0.full, f0.count, f0.overflow, f0.underflow);
    cmp_inst(1, f1.r_data, f1.r_valid, f1.empty, f1.full, f1.count, f1.overflow, f1.underflow);
  end
  task automatic tick(input int m, input int w, input int d, input int r);
    if (m == 0) begin f0.wr = w != 0; f0.w_data = 8'(d); f0.rd = r != 0; end
    else begin f1.wr = w != 0; f1.w_data = 8'(d); f1.rd = r != 0; end
    @(posedge clk);
    #1;
    f0.wr = 1'b0; f0.rd = 1'b0; f1.wr = 1'b0; f1.rd = 1'b0;
    @(negedge clk);
  endtask
  initial begin
    f0.wr = 1'b0; f0.rd = 1'b0; f0.w_data = 8'h00;
    f1.wr = 1'b0; f1.rd = 1'b0; f1.w_data = 8'h00;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk(0, "rst_empty", 32'(f0.empty), 1);
    chk(0, "rst_r_data", 32'(f0.r_data), 0);
    chk(1, "rst_count", 32'(f1.count), 0);
    chk(1, "rst_r_valid", 32'(f1.r_valid), 0);
    for (int i = 0; i < 4; i++) tick(0, 1, 8'hA1 + i, 0);
    chk(0, "t1_full", 32'(f0.full), 1);
    chk(0, "t1_count", 32'(f0.count), 4);
    tick(0, 1, 8'hA5, 0);
    chk(0, "t1_overflow", 32'(f0.overflow), 1);
    chk(0, "t1_count_ovf", 32'(f0.count), 4);
    tick(0, 0, 0, 0);
    chk(0, "t1_overflow_end", 32'(f0.overflow), 0);
    for (int i = 0; i < 4; i++) begin
      tick(0, 0, 0, 1);
      chk(0, "t1_pop_data", 32'(f0.r_data), 8'hA1 + i);
      chk(0, "t1_pop_valid", 32'(f0.r_valid), 1);
    end
    chk(0, "t1_empty", 32'(f0.empty), 1);
    tick(0, 0, 0, 0);
    chk(0, "t1_hold_valid", 32'(f0.r_valid), 0);
    chk(0, "t1_hold_data", 32'(f0.r_data), 8'hA4);
    tick(0, 0, 0, 1);
    chk(0, "t2_underflow", 32'(f0.underflow), 1);
    chk(0, "t2_count", 32'(f0.count), 0);
    chk(0, "t2_r_valid", 32'(f0.r_valid), 0);
    tick(0, 0, 0, 0);
    chk(0, "t2_underflow_end", 32'(f0.underflow), 0);
    for (int r = 0; r < 10; r++) begin
      tick(0, 1, 2 * r, 0);
      tick(0, 1, 2 * r + 1, 0);
      tick(0, 0, 0, 1);
      chk(0, "t3_wrap_data", 32'(f0.r_data), 2 * r);
      tick(0, 0, 0, 1);
      chk(0, "t3_wrap_data", 32'(f0.r_data), 2 * r + 1);
    end
    tick(0, 1, 8'h30, 0);
    tick(0, 1, 8'h31, 0);
    for (int k = 0; k < 5; k++) begin
      tick(0, 1, 8'h32 + k, 1);
      chk(0, "t4_swap_count", 32'(f0.count), 2);
      chk(0, "t4_swap_data", 32'(f0.r_data), 8'h30 + k);
    end
    tick(0, 1, 8'h37, 0);
    tick(0, 1, 8'h38, 0);
    chk(0, "t4_full", 32'(f0.full), 1);
    tick(0, 1, 8'h39, 1);
    chk(0, "t4_full_count", 32'(f0.count), 3);
    chk(0, "t4_full_overflow", 32'(f0.overflow), 1);
    chk(0, "t4_full_data", 32'(f0.r_data), 8'h35);
    for (int k = 0; k < 3; k++) begin
      tick(0, 0, 0, 1);
      chk(0, "t4_drain_data", 32'(f0.r_data), 8'h36 + k);
    end
    tick(1, 0, 0, 1);
    chk(1, "t5_underflow", 32'(f1.underflow), 1);
    tick(1, 1, 8'h5A, 0);
    chk(1, "t5_n0_r_valid", 32'(f1.r_valid), 0);
    tick(1, 0, 0, 0);
    chk(1, "t5_n1_empty", 32'(f1.empty), 1);
    tick(1, 0, 0, 0);
    chk(1, "t5_n2_r_valid", 32'(f1.r_valid), 1);
    chk(1, "t5_n2_r_data", 32'(f1.r_data), 8'h5A);
    chk(1, "t5_n2_empty", 32'(f1.empty), 0);
    tick(1, 0, 0, 1);
    chk(1, "t5_pop_count", 32'(f1.count), 0);
    for (int k = 0; k < 4; k++) tick(1, 1, 8'hB0 + k, 0);
    chk(1, "t5_fill_full", 32'(f1.full), 1);
    chk(1, "t5_fill_count", 32'(f1.count), 4);
    repeat (2) tick(1, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      chk(1, "t5_burst_valid", 32'(f1.r_valid), 1);
      chk(1, "t5_burst_data", 32'(f1.r_data), 8'hB0 + k);
      tick(1, 0, 0, 1);
    end
    chk(1, "t5_burst_empty", 32'(f1.empty), 1);
    for (int k = 0; k < 3; k++) begin
      tick(0, 1, 8'hC0 + k, 0);
      tick(1, 1, 8'hC0 + k, 0);
    end
    chk(0, "t6_pre_count", 32'(f0.count), 3);
    #2 rst_n = 1'b0;
    #1;
    chk(0, "t6_rst_count", 32'(f0.count), 0);
    chk(0, "t6_rst_empty", 32'(f0.empty), 1);
    chk(0, "t6_rst_r_data", 32'(f0.r_data), 0);
    chk(1, "t6_rst_count", 32'(f1.count), 0);
    chk(1, "t6_rst_r_valid", 32'(f1.r_valid), 0);
    chk(1, "t6_rst_empty", 32'(f1.empty), 1);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    tick(1, 1, 8'h77, 0);
    tick(0, 1, 8'h77, 0);
    tick(0, 0, 0, 1);
    chk(0, "t6_first_word", 32'(f0.r_data), 8'h77);
    chk(1, "t6_first_valid", 32'(f1.r_valid), 1);
    chk(1, "t6_first_word", 32'(f1.r_data), 8'h77);
    tick(1, 0, 0, 1);
    chk(1, "t6_final_empty", 32'(f1.empty), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
